// File: rtl/ln_ctrl_pkg.sv
// Shared types for the layer-norm engine arbiter: FSM state encoding and
// the engine status codes seen on eng_state.
package ln_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DELIVER,
        ST_RELEASE,
        ST_FAULT
    } arb_state_t;

    localparam logic [1:0] ENG_IDLE = 2'b00;
    localparam logic [1:0] ENG_RUN  = 2'b01;
    localparam logic [1:0] ENG_DONE = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit above `last`, wrapping.
// Zero latency; no flow control, the caller decides when the result is used.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] winner,
    output logic            any
);

    logic [IDXW-1:0] w_cand;

    // Walk last+1 .. last+NREQ; the first hit wins, later hits are masked by `any`.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDXW'((int'(last) + k) % NREQ);
            if (!any && req[w_cand]) begin
                winner = w_cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ln_arbiter.sv
// Round-robin share of one layer-norm engine; grant 1 cycle after req is seen in IDLE.
// Holds rsp_valid until rsp_taken[sel]; a RUN phase longer than TIMEOUT traps in FAULT.
module ln_arbiter
    import ln_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDXW    = $clog2(NREQ),
    parameter int TIMEOUT = 1024,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] sel,
    output logic            busy,
    output logic            eng_input_ready,
    output logic            eng_output_taken,
    input  logic [1:0]      eng_state,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_taken,
    output logic            fault,
    output logic [IDXW-1:0] fault_idx
);

    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT - 1);

    arb_state_t      r_state;
    logic [IDXW-1:0] r_last;
    logic [IDXW-1:0] r_sel;
    logic [IDXW-1:0] r_fault_idx;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_fault;
    logic [TW-1:0]   r_wdog;

    logic [IDXW-1:0] w_winner;
    logic            w_any;
    logic            w_taken;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_taken = rsp_taken[r_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= IDXW'(NREQ - 1);
            r_sel       <= '0;
            r_fault_idx <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_winner;
                        r_gnt   <= NREQ'(1) << w_winner;
                        r_busy  <= 1'b1;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (eng_state == ENG_RUN) begin
                        r_wdog  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (eng_state == ENG_DONE) begin
                        r_state <= ST_DELIVER;
                    end else if (r_wdog == WD_LIMIT) begin
                        r_fault     <= 1'b1;
                        r_fault_idx <= r_sel;
                        r_state     <= ST_FAULT;
                    end
                end
                ST_DELIVER: begin
                    if (w_taken) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Rotation pointer only advances once the engine has fully drained.
                    if (eng_state == ENG_IDLE) begin
                        r_last  <= r_sel;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == ST_DELIVER) begin
            rsp_valid[r_sel] = 1'b1;
        end
    end

    assign eng_input_ready  = (r_state == ST_LAUNCH);
    assign eng_output_taken = (r_state == ST_DELIVER) && w_taken;

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = r_busy;
    assign fault     = r_fault;
    assign fault_idx = r_fault_idx;

endmodule

// File: tb/tb_ln_arbiter.sv
// Bench for ln_arbiter: behavioural engine models, round-robin reference and
// per-scenario tasks; a second instance with a short watchdog covers the fault path.
module tb_ln_arbiter;
    import ln_ctrl_pkg::*;

    localparam int NREQ  = 4;
    localparam int IDXW  = 2;
    localparam int TO_WD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, reset_wd;
    logic [NREQ-1:0] req, gnt, rsp_valid, rsp_taken;
    logic [IDXW-1:0] sel, fault_idx;
    logic            busy, eng_input_ready, eng_output_taken, fault;
    logic [1:0]      eng_state;

    logic [NREQ-1:0] req_wd, gnt_wd, rsp_valid_wd, rsp_taken_wd;
    logic [IDXW-1:0] sel_wd, fault_idx_wd;
    logic            busy_wd, eng_input_ready_wd, eng_output_taken_wd, fault_wd;
    logic [1:0]      eng_state_wd;

    ln_arbiter #(.NREQ(NREQ)) u_dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .sel(sel), .busy(busy),
        .eng_input_ready(eng_input_ready), .eng_output_taken(eng_output_taken),
        .eng_state(eng_state), .rsp_valid(rsp_valid), .rsp_taken(rsp_taken),
        .fault(fault), .fault_idx(fault_idx)
    );

    ln_arbiter #(.NREQ(NREQ), .TIMEOUT(TO_WD)) u_wd (
        .clk(clk), .reset(reset_wd), .req(req_wd), .gnt(gnt_wd), .sel(sel_wd), .busy(busy_wd),
        .eng_input_ready(eng_input_ready_wd), .eng_output_taken(eng_output_taken_wd),
        .eng_state(eng_state_wd), .rsp_valid(rsp_valid_wd), .rsp_taken(rsp_taken_wd),
        .fault(fault_wd), .fault_idx(fault_idx_wd)
    );

    int n_chk = 0;
    int n_fail = 0;
    int eng_lat = 20;
    int eng_cnt;
    int last_model;

    // Clocked engine: accepts on input_ready, reports run for eng_lat cycles, then done.
    always @(posedge clk) begin
        if (reset) begin
            eng_state <= ENG_IDLE;
            eng_cnt   <= 0;
        end else begin
            case (eng_state)
                ENG_IDLE: if (eng_input_ready) begin eng_state <= ENG_RUN; eng_cnt <= eng_lat; end
                ENG_RUN:  if (eng_cnt <= 1) eng_state <= ENG_DONE; else eng_cnt <= eng_cnt - 1;
                default:  if (eng_output_taken) eng_state <= ENG_IDLE;
            endcase
        end
    end

    // Engine that accepts and then never finishes.
    always @(posedge clk) begin
        if (reset_wd) eng_state_wd <= ENG_IDLE;
        else if (eng_input_ready_wd) eng_state_wd <= ENG_RUN;
    end

    int g_q[$];
    int s_q[$];
    int g_cyc[$];
    int cyc = 0;
    int rv_cnt = 0;
    int ot_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (gnt != '0) begin
            for (int i = 0; i < NREQ; i++) if (gnt[i]) g_q.push_back(i);
            s_q.push_back(int'(sel));
            g_cyc.push_back(cyc);
        end
        if (rsp_valid != '0) rv_cnt++;
        if (eng_output_taken) ot_cnt++;
    end

    function automatic int rr_ref(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        req = '0; rsp_taken = '0; reset = 1'b1;
        tick_n(3);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_n(1);
            n_chk++;
            if ({gnt, sel, busy, eng_input_ready, eng_output_taken, rsp_valid, fault, fault_idx} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h required 0", i,
                         {gnt, sel, busy, eng_input_ready, eng_output_taken, rsp_valid, fault, fault_idx});
            end
        end
        last_model = NREQ - 1;
        req = 4'b0001;
        tick_n(1);
        n_chk++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1 || eng_input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: gnt=%b sel=%0d busy=%b ir=%b required 0001 0 1 1", gnt, sel, busy, eng_input_ready);
        end
        req = '0;
        tick_n(1);
        n_chk++;
        if (gnt !== '0 || eng_input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_pulse: gnt=%b ir=%b required 0000 1", gnt, eng_input_ready);
        end
        tick_n(1);
        n_chk++;
        if (eng_input_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL launch_exit: ir=%b required 0", eng_input_ready);
        end
        eng_lat = 4;
        rsp_taken = '1;
        wait_idle(200, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL first_done: busy=%b required 0 within budget", busy); end
        last_model = 0;
        rsp_taken = '0;
    endtask

    task automatic test_rotation();
        bit ok;
        int exp_i;
        reset = 1'b1; tick_n(2); reset = 1'b0;
        last_model = NREQ - 1;
        eng_lat = 20;
        rsp_taken = '1;
        g_q.delete(); s_q.delete(); g_cyc.delete();
        req = '1;
        for (int i = 0; i < 1000 && g_q.size() < 5; i++) tick_n(1);
        req = '0;
        n_chk++;
        if (g_q.size() < 5) begin
            n_fail++;
            $display("FAIL rotation_count: grants=%0d required 5", g_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_i = rr_ref(4'b1111, last_model);
                last_model = exp_i;
                n_chk++;
                if (g_q[i] != exp_i || s_q[i] != exp_i) begin
                    n_fail++;
                    $display("FAIL rotation_order #%0d: gnt=%0d sel=%0d required %0d", i, g_q[i], s_q[i], exp_i);
                end
                if (i > 0) begin
                    n_chk++;
                    if (g_cyc[i] - g_cyc[i-1] != eng_lat + 5) begin
                        n_fail++;
                        $display("FAIL back_to_back #%0d: gap=%0d required %0d", i, g_cyc[i] - g_cyc[i-1], eng_lat + 5);
                    end
                end
            end
        end
        wait_idle(200, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL rotation_idle: busy=%b required 0", busy); end
        rsp_taken = '0;
    endtask

    task automatic test_sparse_wrap();
        bit ok;
        logic [NREQ-1:0] pats [2];
        int exp_i;
        pats[0] = 4'b0100;
        pats[1] = 4'b0011;
        eng_lat = 3;
        for (int p = 0; p < 2; p++) begin
            exp_i = rr_ref(pats[p], last_model);
            req = pats[p];
            tick_n(1);
            req = '0;
            n_chk++;
            if (gnt !== onehot(exp_i) || sel !== IDXW'(exp_i)) begin
                n_fail++;
                $display("FAIL sparse_wrap #%0d: gnt=%b sel=%0d required %b %0d", p, gnt, sel, onehot(exp_i), exp_i);
            end
            rsp_taken = '1;
            wait_idle(200, ok);
            rsp_taken = '0;
            last_model = exp_i;
            n_chk++;
            if (!ok) begin n_fail++; $display("FAIL sparse_idle #%0d: busy=%b required 0", p, busy); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int exp_i, rv0, ot0;
        eng_lat = 5;
        rsp_taken = '0;
        exp_i = rr_ref(4'b0010, last_model);
        req = 4'b0010;
        tick_n(1);
        req = '0;
        n_chk++;
        if (gnt !== onehot(exp_i)) begin
            n_fail++;
            $display("FAIL bp_grant: gnt=%b required %b", gnt, onehot(exp_i));
        end
        wait_valid(200, ok);
        rv0 = rv_cnt; ot0 = ot_cnt;
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL bp_deliver: rsp_valid=%b required nonzero", rsp_valid); end
        for (int i = 0; i < 7; i++) begin
            rsp_taken = NREQ'($urandom) & ~onehot(exp_i);
            #1;
            n_chk++;
            if (rsp_valid !== onehot(exp_i) || eng_output_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: rsp_valid=%b ot=%b required %b 0", i, rsp_valid, eng_output_taken, onehot(exp_i));
            end
            tick_n(1);
        end
        rsp_taken = onehot(exp_i);
        #1;
        n_chk++;
        if (rsp_valid !== onehot(exp_i) || eng_output_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_take: rsp_valid=%b ot=%b required %b 1", rsp_valid, eng_output_taken, onehot(exp_i));
        end
        tick_n(3);
        n_chk++;
        if (rv_cnt - rv0 != 8 || ot_cnt - ot0 != 1) begin
            n_fail++;
            $display("FAIL bp_counts: valid_cycles=%0d taken_pulses=%0d required 8 1", rv_cnt - rv0, ot_cnt - ot0);
        end
        wait_idle(200, ok);
        rsp_taken = '0;
        last_model = exp_i;
    endtask

    task automatic test_random();
        bit ok;
        logic [NREQ-1:0] r;
        int exp_i, d;
        for (int t = 0; t < 12; t++) begin
            r = NREQ'($urandom_range(1, 15));
            eng_lat = $urandom_range(1, 30);
            d = $urandom_range(0, 4);
            exp_i = rr_ref(r, last_model);
            rsp_taken = '0;
            req = r;
            tick_n(1);
            req = '0;
            n_chk++;
            if (gnt !== onehot(exp_i) || sel !== IDXW'(exp_i)) begin
                n_fail++;
                $display("FAIL rand_grant #%0d req=%b: gnt=%b sel=%0d required %b %0d", t, r, gnt, sel, onehot(exp_i), exp_i);
            end
            wait_valid(200, ok);
            for (int i = 0; i < d; i++) begin
                rsp_taken = NREQ'($urandom) & ~onehot(exp_i);
                #1;
                n_chk++;
                if (rsp_valid !== onehot(exp_i) || eng_output_taken !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_hold #%0d: rsp_valid=%b ot=%b required %b 0", t, rsp_valid, eng_output_taken, onehot(exp_i));
                end
                tick_n(1);
            end
            rsp_taken = onehot(exp_i) | NREQ'($urandom);
            #1;
            n_chk++;
            if (!ok || rsp_valid !== onehot(exp_i) || eng_output_taken !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_take #%0d: rsp_valid=%b ot=%b required %b 1", t, rsp_valid, eng_output_taken, onehot(exp_i));
            end
            wait_idle(200, ok);
            last_model = exp_i;
        end
        rsp_taken = '0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        eng_lat = 3;
        rsp_taken = '1;
        req = 4'b0001;
        tick_n(1);
        req = '0;
        wait_idle(200, ok);
        rsp_taken = '0;
        req = 4'b0100;
        tick_n(1);
        req = '0;
        wait_valid(200, ok);
        n_chk++;
        if (!ok || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL midrst_setup: sel=%0d rsp_valid=%b required 2 0100", sel, rsp_valid);
        end
        reset = 1'b1;
        tick_n(1);
        n_chk++;
        if (rsp_valid !== '0 || busy !== 1'b0 || gnt !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: rsp_valid=%b busy=%b gnt=%b required 0000 0 0000", rsp_valid, busy, gnt);
        end
        reset = 1'b0;
        last_model = NREQ - 1;
        req = '1;
        tick_n(1);
        req = '0;
        n_chk++;
        if (gnt !== onehot(rr_ref(4'b1111, last_model))) begin
            n_fail++;
            $display("FAIL midrst_regrant: gnt=%b required %b", gnt, onehot(rr_ref(4'b1111, last_model)));
        end
        rsp_taken = '1;
        wait_idle(200, ok);
        rsp_taken = '0;
    endtask

    task automatic test_watchdog();
        bit ok;
        int n, extra;
        req_wd = '0; rsp_taken_wd = '0;
        reset_wd = 1'b1; tick_n(2); reset_wd = 1'b0;
        req_wd = 4'b0100;
        tick_n(1);
        req_wd = '0;
        n_chk++;
        if (gnt_wd !== 4'b0100) begin n_fail++; $display("FAIL wd_grant: gnt=%b required 0100", gnt_wd); end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick_n(1);
            if (eng_input_ready_wd === 1'b0) ok = 1'b1;
        end
        n = 0;
        while (ok && fault_wd !== 1'b1 && n < 100) begin
            tick_n(1);
            n++;
        end
        n_chk++;
        if (!ok || n != TO_WD) begin
            n_fail++;
            $display("FAIL wd_latency: cycles_to_fault=%0d required %0d", n, TO_WD);
        end
        n_chk++;
        if (fault_idx_wd !== 2'd2 || busy_wd !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_idx: fault_idx=%0d busy=%b required 2 1", fault_idx_wd, busy_wd);
        end
        req_wd = '1;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            tick_n(1);
            if (gnt_wd !== '0) extra++;
        end
        n_chk++;
        if (extra != 0 || fault_wd !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_sticky: grants=%0d fault=%b required 0 1", extra, fault_wd);
        end
        req_wd = '0;
        reset_wd = 1'b1;
        tick_n(1);
        reset_wd = 1'b0;
        n_chk++;
        if (fault_wd !== 1'b0 || busy_wd !== 1'b0 || fault_idx_wd !== 2'd0) begin
            n_fail++;
            $display("FAIL wd_reset: fault=%b busy=%b idx=%0d required 0 0 0", fault_wd, busy_wd, fault_idx_wd);
        end
    endtask

    initial begin
        reset = 1'b1; reset_wd = 1'b1;
        req = '0; rsp_taken = '0; req_wd = '0; rsp_taken_wd = '0;
        test_reset();
        test_rotation();
        test_sparse_wrap();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
